// File: rtl/encoder_83_evt.sv
// Sequential 8-to-3 priority event encoder with valid/ready output and 74x148-style
// cascade/status pins. Requests on I_n are synchronised, latched as pending, drained highest first.
module encoder_83_evt #(
   parameter bit EDGE_DET = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       EI_n,
   input  logic [7:0] I_n,
   output logic [2:0] A,
   output logic       valid,
   input  logic       ready,
   output logic       GS_n,
   output logic       EO_n,
   output logic       overflow
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t     state_q, state_d;
   logic [7:0] s1_q, s1_d;
   logic [7:0] s2_q, s2_d;
   logic [7:0] s2_dly_q, s2_dly_d;
   logic [7:0] pend_q, pend_d;
   logic [2:0] a_q, a_d;
   logic       ovf_q, ovf_d;
   logic [7:0] evt, clr_mask, rest;
   logic       accept;

   function automatic logic [2:0] top_idx(input logic [7:0] v);
      top_idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) top_idx = i[2:0];
   endfunction

   always_comb begin
      s1_d     = I_n;
      s2_d     = s1_q;
      s2_dly_d = s2_q;

      evt = EDGE_DET ? (s2_dly_q & ~s2_q) : ~s2_q;
      if (EI_n) evt = 8'h00;

      accept   = (state_q == PRESENT) && ready;
      clr_mask = accept ? (8'b1 << a_q) : 8'h00;
      // A new event on the bit being cleared keeps it pending (set wins).
      rest     = (pend_q & ~clr_mask) | evt;
      pend_d   = rest;
      ovf_d    = EDGE_DET & (|(evt & pend_q & ~clr_mask));

      state_d = state_q;
      a_d     = a_q;
      case (state_q)
         IDLE: begin
            if (|pend_q) begin
               a_d     = top_idx(pend_q);
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            // A is frozen until accepted; higher newcomers wait for the next load.
            if (accept) begin
               if (|rest) a_d = top_idx(rest);
               else       state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 8'hFF;
         s2_q     <= 8'hFF;
         s2_dly_q <= 8'hFF;
         pend_q   <= 8'h00;
         a_q      <= 3'd0;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s2_dly_q <= s2_dly_d;
         pend_q   <= pend_d;
         a_q      <= a_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
      end
   end

   assign A        = a_q;
   assign valid    = (state_q == PRESENT);
   assign overflow = ovf_q;
   assign GS_n     = ~((|pend_q) | valid);
   assign EO_n     = ~(~EI_n & ~(|pend_q) & ~valid);

endmodule
